rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Writer-side companion to the core register file: owns its single write port (wen/waddr/wdata).
- Arbitrates results from three producers into that port: ALU (single-cycle), LSU (load), MULDIV (long latency).
- Keeps a pending-write scoreboard for long-latency destinations so decode can stall on RAW/WAW hazards.
- Provides a one-cycle bypass for the write currently in flight to the register file.

Parameters:
- XLEN, 32, data width of results and write port
- NREG, 32, number of architectural registers (address width = log2 NREG = 5)
- STARVE_LIMIT, 4, consecutive cycles MULDIV may be refused before it outranks LSU

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alu_valid  in  1  ALU result present (always accepted)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load result present
- lsu_rd  in  5  load destination
- lsu_data  in  XLEN  load result
- lsu_ready  out  1  load result accepted this cycle
- md_valid  in  1  MULDIV result present
- md_rd  in  5  MULDIV destination
- md_data  in  XLEN  MULDIV result
- md_ready  out  1  MULDIV result accepted this cycle
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination
- issue_ready  out  1  issue permitted (no WAW on issue_rd)
- rs1  in  5  decode source 1
- rs2  in  5  decode source 2
- rs1_busy  out  1  rs1 has pending long-latency write
- rs2_busy  out  1  rs2 has pending long-latency write
- rs1_fwd  out  1  rs1 matches in-flight write
- rs2_fwd  out  1  rs2 matches in-flight write
- fwd_data  out  XLEN  data of in-flight write (wdata)
- wen  out  1  register file write enable
- waddr  out  5  register file write address
- wdata  out  XLEN  register file write data

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: busy vector=0, wen=0, waddr=0, wdata=0, starve counter=0. rst mid-operation drops any in-flight write and all pending marks; held producers must re-present.
- Arbitration, combinational per cycle:
  - alu_valid wins unconditionally.
  - Otherwise LSU beats MULDIV, unless starve counter == STARVE_LIMIT, in which case MULDIV beats LSU.
  - lsu_ready / md_ready are high only for the winner.
- Producer contract: LSU and MULDIV hold valid, rd and data stable until ready.
- Starve counter: increments (saturating at STARVE_LIMIT) when md_valid && !md_ready; clears when md_ready or !md_valid.
- Write port (registered, latency 1): the accepted result loads waddr/wdata at the edge and wen=1 for the following cycle; if nothing is accepted, wen=0 and waddr/wdata hold.
  - rd==0 results are consumed (ready asserted) but produce wen=0.
- Scoreboard, NREG bits, bit 0 hardwired 0:
  - issue_valid && issue_ready && issue_rd!=0 sets busy[issue_rd].
  - md accepted clears busy[md_rd].
  - Same-cycle set and clear of the same rd: set wins.
  - issue_ready = !busy[issue_rd]; issue_valid with issue_ready=0 is ignored.
- Hazard outputs (combinational):
  - rsN_busy = busy[rsN].
  - rsN_fwd = wen && waddr==rsN && rsN!=0.
  - fwd_data = wdata.
  - Busy clears at the same edge the write is registered, so the cycle after acceptance shows busy=0 with fwd=1; the cycle after that, the register file holds the value.
- ALU and LSU destinations are not tracked in the scoreboard; the in-order pipeline covers them.

Decomposition:
- Shared package (def.sv) holds:
  - XLEN, NREG and the register address width.
  - A wb_req typedef {valid, rd, data}.
  - Source select encoding SRC_NONE/ALU/LSU/MD.
- Natural sub-module: rf_scoreboard, which owns the busy vector, set/clear priority, issue_ready and rs1/rs2_busy lookup.
- Arbiter, starve counter, write register and forwarding stay in rf_writeback.

Test Plan:
- Reset then idle 5 cycles -> wen=0, waddr=0, wdata=0, all busy/fwd outputs 0.
- alu_valid, rd=5, data=0xDEADBEEF alongside lsu_valid rd=6 -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF, lsu_ready=0; lsu written the following cycle; rs1=5 shows rs1_fwd=1 during the wen cycle.
- issue rd=10; MULDIV returns rd=10, 0x1234 three cycles later -> rs1_busy=1 (rs1=10) until the acceptance edge, then rs1_fwd=1 with fwd_data=0x1234, then both 0; second issue to rd=10 while busy sees issue_ready=0.
- md_valid held with lsu_valid continuously asserted -> lsu wins 4 cycles, md_ready=1 on cycle 5 (STARVE_LIMIT=4), counter returns to 0.
- lsu result rd=0, data=0xFFFF -> lsu_ready=1, wen stays 0, no fwd hits for rs1=0.
- Same-cycle md accept rd=7 and issue rd=7 (issue_ready forced by prior clear) -> busy[7]=1 afterwards; assert rst during pending write -> wen=0 and busy cleared next cycle.

Source files
------------

// File: rtl/rf_writeback_pkg.sv
// Shared definitions for the register-file writeback slice: sizes, result
// request record and the writeback source select encoding.
package rf_writeback_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RA_W = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MD   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: one busy bit per
// architectural register, x0 never busy, a same-cycle set beats a clear.
module rf_scoreboard
  import rf_writeback_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid_i,
  input  logic [RA_W-1:0] issue_rd_i,
  output logic            issue_ready_o,
  input  logic            clr_valid_i,
  input  logic [RA_W-1:0] clr_rd_i,
  input  logic [RA_W-1:0] rs1_i,
  input  logic [RA_W-1:0] rs2_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  assign issue_ready_o = !busy_q[issue_rd_i];
  assign rs1_busy_o    = busy_q[rs1_i];
  assign rs2_busy_o    = busy_q[rs2_i];

  // Clear first so a same-cycle set of the same register survives.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_rd_i] = 1'b0;
    if (issue_valid_i && issue_ready_o) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write port owner: arbitrates ALU/LSU/MULDIV results, tracks
// pending long-latency writes and exposes a bypass of the write in flight.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  input  logic [RA_W-1:0] lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            md_valid,
  input  logic [RA_W-1:0] md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  input  logic            issue_valid,
  input  logic [RA_W-1:0] issue_rd,
  output logic            issue_ready,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] fwd_data,
  output logic            wen,
  output logic [RA_W-1:0] waddr,
  output logic [XLEN-1:0] wdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  wb_src_e         sel;
  wb_req_t         win;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            wen_q;
  logic [RA_W-1:0] waddr_q;
  logic [XLEN-1:0] wdata_q;

  // ALU is never refused; MULDIV outranks LSU only once it has starved.
  always_comb begin
    sel = SRC_NONE;
    if (alu_valid)                  sel = SRC_ALU;
    else if (lsu_valid && md_valid) sel = (starve_q == STARVE_MAX) ? SRC_MD : SRC_LSU;
    else if (lsu_valid)             sel = SRC_LSU;
    else if (md_valid)              sel = SRC_MD;
  end

  assign lsu_ready = (sel == SRC_LSU);
  assign md_ready  = (sel == SRC_MD);

  always_comb begin
    win = '0;
    unique case (sel)
      SRC_ALU:  win = '{valid: 1'b1, rd: alu_rd, data: alu_data};
      SRC_LSU:  win = '{valid: 1'b1, rd: lsu_rd, data: lsu_data};
      SRC_MD:   win = '{valid: 1'b1, rd: md_rd,  data: md_data};
      SRC_NONE: win = '0;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (md_valid && !md_ready)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
  end

  // ---- write register stage: result visible to the register file next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= win.valid && (win.rd != '0);
      if (win.valid) begin
        waddr_q <= win.rd;
        wdata_q <= win.data;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .issue_ready_o(issue_ready),
    .clr_valid_i  (md_ready),
    .clr_rd_i     (md_rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy)
  );

  assign wen      = wen_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign fwd_data = wdata_q;
  assign rs1_fwd  = wen_q && (waddr_q == rs1) && (rs1 != '0);
  assign rs2_fwd  = wen_q && (waddr_q == rs2) && (rs2 != '0);

endmodule

// File: tb/tb_rf_writeback.sv
// Directed plus randomized bench for rf_writeback with a behavioural model
// of arbitration, starvation, write port and pending-write tracking.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, md_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, md_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data, md_data;
  logic        lsu_ready, md_ready, issue_ready;
  logic        rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, wen;
  logic [31:0] fwd_data, wdata;
  logic [4:0]  waddr;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit [31:0] m_busy;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  int        m_starve;
  bit        l_acc, m_acc;

  always #5 clk = ~clk;

  rf_writeback #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 none, 1 alu, 2 lsu, 3 muldiv
  function automatic int m_win();
    if (alu_valid) return 1;
    if (lsu_valid && md_valid) return (m_starve == 4) ? 3 : 2;
    if (lsu_valid) return 2;
    if (md_valid) return 3;
    return 0;
  endfunction

  // Called just after a negedge with inputs settled; checks, then advances one cycle.
  task automatic tick();
    int w;
    bit ir;
    w = m_win();
    #1;
    chk("lsu_ready", 32'(lsu_ready), 32'(w == 2));
    chk("md_ready", 32'(md_ready), 32'(w == 3));
    chk("issue_ready", 32'(issue_ready), 32'(!m_busy[issue_rd]));
    chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1]));
    chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2]));
    chk("rs1_fwd", 32'(rs1_fwd), 32'(m_wen && m_waddr == rs1 && rs1 != 0));
    chk("rs2_fwd", 32'(rs2_fwd), 32'(m_wen && m_waddr == rs2 && rs2 != 0));
    chk("wen", 32'(wen), 32'(m_wen));
    chk("waddr", 32'(waddr), 32'(m_waddr));
    chk("wdata", wdata, m_wdata);
    chk("fwd_data", fwd_data, m_wdata);
    l_acc = lsu_ready;
    m_acc = md_ready;
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_starve = 0;
    end else begin
      ir = !m_busy[issue_rd];
      m_wen = 0;
      case (w)
        1: begin m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data; end
        2: begin m_wen = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data; end
        3: begin m_wen = (md_rd != 0);  m_waddr = md_rd;  m_wdata = md_data;  end
        default: ;
      endcase
      if (md_valid && w != 3) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
      else m_starve = 0;
      if (w == 3) m_busy[md_rd] = 1'b0;
      if (issue_valid && ir && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; md_valid = 0; issue_valid = 0;
    alu_rd = '0; lsu_rd = '0; md_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
    alu_data = '0; lsu_data = '0; md_data = '0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_starve = 0;
    @(negedge clk);
    tick();
    rst = 0;

    // Idle after reset
    repeat (5) tick();
    chk("idle_wen", 32'(wen), 32'd0);
    chk("idle_wdata", wdata, 32'd0);

    // ALU beats LSU; LSU written the cycle after
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 32'hCAFE0006; rs1 = 5'd5;
    #1 chk("alu_over_lsu", 32'(lsu_ready), 32'd0);
    tick();
    alu_valid = 0;
    #1 chk("alu_fwd", 32'(rs1_fwd), 32'd1);
    chk("alu_wdata", wdata, 32'hDEADBEEF);
    tick();
    lsu_valid = 0;
    #1 chk("lsu_waddr", 32'(waddr), 32'd6);
    tick();

    // Long-latency issue, WAW block, return, forward window
    issue_valid = 1; issue_rd = 5'd10; rs1 = 5'd10;
    tick();
    issue_valid = 0;
    #1 chk("md_busy", 32'(rs1_busy), 32'd1);
    tick();
    issue_valid = 1;
    #1 chk("waw_block", 32'(issue_ready), 32'd0);
    tick();
    issue_valid = 0;
    md_valid = 1; md_rd = 5'd10; md_data = 32'h1234;
    tick();
    md_valid = 0;
    #1 chk("md_busy_clr", 32'(rs1_busy), 32'd0);
    chk("md_fwd", 32'(rs1_fwd), 32'd1);
    chk("md_fwd_data", fwd_data, 32'h1234);
    tick();
    #1 chk("md_fwd_gone", 32'(rs1_fwd), 32'd0);
    tick();

    // Starvation: LSU streams, MULDIV waits 4 cycles then wins the 5th
    md_valid = 1; md_rd = 5'd3; md_data = 32'h0000_0333;
    lsu_valid = 1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      lsu_rd = 5'(i + 10); lsu_data = 32'(i);
      #0;
      if (md_ready && n == 0) n = i;
      tick();
      if (m_acc) break;
    end
    chk("starve_cycle", 32'(n), 32'd5);
    md_valid = 0; lsu_valid = 0;
    tick();

    // rd==0 is consumed without a write
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFF; rs1 = 5'd0;
    #1 chk("rd0_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 0;
    #1 chk("rd0_wen", 32'(wen), 32'd0);
    chk("rd0_fwd", 32'(rs1_fwd), 32'd0);
    tick();

    // Same-cycle clear and set of rd 7: set wins
    md_valid = 1; md_rd = 5'd7; md_data = 32'h77;
    issue_valid = 1; issue_rd = 5'd7; rs1 = 5'd7;
    tick();
    md_valid = 0; issue_valid = 0;
    #1 chk("set_wins", 32'(rs1_busy), 32'd1);
    // Reset drops in-flight write and pending marks
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99; rst = 1;
    tick();
    alu_valid = 0; rst = 0;
    #1 chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_busy", 32'(rs1_busy), 32'd0);
    tick();

    // Randomized traffic honouring the hold-until-ready contract
    l_acc = 0; m_acc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!lsu_valid || l_acc) begin
        lsu_valid = ($urandom_range(0, 1) == 1);
        lsu_rd = 5'($urandom); lsu_data = $urandom;
      end
      if (!md_valid || m_acc) begin
        md_valid = ($urandom_range(0, 2) != 0);
        md_rd = 5'($urandom); md_data = $urandom;
      end
      alu_valid = ($urandom_range(0, 3) == 0);
      alu_rd = 5'($urandom); alu_data = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      if (rst) begin lsu_valid = 0; md_valid = 0; end
      tick();
      if (rst) begin l_acc = 0; m_acc = 0; end
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
